// File: rtl/morse_pkg.sv
// Shared timing default, FSM state types and the A-Z Morse code table
// used by both halves of the Morse codec.
package morse_pkg;

  localparam int         UNIT_DEFAULT = 16;
  localparam logic [4:0] LAST_LETTER  = 5'd25;
  localparam logic [4:0] LETTER_MISS  = 5'd31;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_MARK,
    TX_SPACE,
    TX_LGAP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_ON,
    RX_OFF
  } rx_state_e;

  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pattern;
  } morse_code_t;

  // Pattern is right-aligned in its len-bit field; the first element sent
  // is the field's MSB, and a 1 bit means dash.
  function automatic morse_code_t codeOf(input logic [4:0] idx);
    morse_code_t c;
    case (idx)
      5'd0:    c = '{3'd2, 4'b0001};
      5'd1:    c = '{3'd4, 4'b1000};
      5'd2:    c = '{3'd4, 4'b1010};
      5'd3:    c = '{3'd3, 4'b0100};
      5'd4:    c = '{3'd1, 4'b0000};
      5'd5:    c = '{3'd4, 4'b0010};
      5'd6:    c = '{3'd3, 4'b0110};
      5'd7:    c = '{3'd4, 4'b0000};
      5'd8:    c = '{3'd2, 4'b0000};
      5'd9:    c = '{3'd4, 4'b0111};
      5'd10:   c = '{3'd3, 4'b0101};
      5'd11:   c = '{3'd4, 4'b0100};
      5'd12:   c = '{3'd2, 4'b0011};
      5'd13:   c = '{3'd2, 4'b0010};
      5'd14:   c = '{3'd3, 4'b0111};
      5'd15:   c = '{3'd4, 4'b0110};
      5'd16:   c = '{3'd4, 4'b1101};
      5'd17:   c = '{3'd3, 4'b0010};
      5'd18:   c = '{3'd3, 4'b0000};
      5'd19:   c = '{3'd1, 4'b0001};
      5'd20:   c = '{3'd3, 4'b0001};
      5'd21:   c = '{3'd4, 4'b0001};
      5'd22:   c = '{3'd3, 4'b0011};
      5'd23:   c = '{3'd4, 4'b1001};
      5'd24:   c = '{3'd4, 4'b1011};
      5'd25:   c = '{3'd4, 4'b1100};
      default: c = '{3'd0, 4'b0000};
    endcase
    return c;
  endfunction

  function automatic logic [4:0] indexOf(input logic [2:0] len, input logic [3:0] pattern);
    logic [4:0]  idx;
    morse_code_t c;
    idx = LETTER_MISS;
    for (int i = 0; i <= 25; i++) begin
      c = codeOf(5'(i));
      if (c.len == len && c.pattern == pattern) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/morse_rx_fsm.sv
// Morse receiver: times key-down and key-up periods, classifies dots and
// dashes, and decodes each finished letter into an index or an error.
module morse_rx_fsm
  import morse_pkg::*;
#(
  parameter int UNIT = UNIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_i,
  output logic [4:0] letter_o,
  output logic       error_o,
  output logic       valid_o
);

  localparam int            CW       = $clog2(2 * UNIT) + 1;
  localparam logic [CW-1:0] DASH_MIN = CW'(2 * UNIT);
  localparam logic [CW-1:0] GAP_LAST = CW'(2 * UNIT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  rx_state_e     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] countInc;
  logic [3:0]    pattern_q, pattern_d;
  logic [2:0]    elems_q, elems_d;
  logic [4:0]    letter_q, letter_d;
  logic          error_q, error_d;
  logic          valid_q, valid_d;
  logic [4:0]    lookup;

  assign countInc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
  assign lookup   = indexOf(elems_q, pattern_q);

  // The element counter saturates at 7 so runs of more than four elements
  // stay recognisable as errors however long they get.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pattern_d = pattern_q;
    elems_d   = elems_q;
    letter_d  = letter_q;
    error_d   = error_q;
    valid_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (key_i) begin
          state_d = RX_ON;
          count_d = CW'(1);
        end
      end
      RX_ON: begin
        if (key_i) begin
          count_d = countInc;
        end else begin
          pattern_d = {pattern_q[2:0], count_q >= DASH_MIN};
          elems_d   = (elems_q == 3'd7) ? elems_q : elems_q + 3'd1;
          count_d   = CW'(1);
          state_d   = RX_OFF;
        end
      end
      RX_OFF: begin
        if (key_i) begin
          state_d = RX_ON;
          count_d = CW'(1);
        end else if (count_q >= GAP_LAST) begin
          valid_d   = 1'b1;
          state_d   = RX_IDLE;
          count_d   = '0;
          pattern_d = '0;
          elems_d   = '0;
          if (elems_q > 3'd4 || lookup == LETTER_MISS) begin
            letter_d = LETTER_MISS;
            error_d  = 1'b1;
          end else begin
            letter_d = lookup;
            error_d  = 1'b0;
          end
        end else begin
          count_d = countInc;
        end
      end
      default: begin
        state_d = RX_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      count_q   <= '0;
      pattern_q <= '0;
      elems_q   <= '0;
      letter_q  <= '0;
      error_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pattern_q <= pattern_d;
      elems_q   <= elems_d;
      letter_q  <= letter_d;
      error_q   <= error_d;
      valid_q   <= valid_d;
    end
  end

  assign letter_o = letter_q;
  assign error_o  = error_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/morse_tx_fsm.sv
// Morse transmitter: turns an accepted letter index into timed key-on/key-off
// marks, spaces and a closing letter gap.
module morse_tx_fsm
  import morse_pkg::*;
#(
  parameter int UNIT = UNIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_i,
  input  logic [4:0] letter_i,
  output logic       key_o,
  output logic       busy_o
);

  localparam int            CW        = $clog2(3 * UNIT);
  localparam logic [CW-1:0] DOT_LAST  = CW'(UNIT - 1);
  localparam logic [CW-1:0] DASH_LAST = CW'(3 * UNIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    pattern_q, pattern_d;
  logic [2:0]    remain_q, remain_d;
  logic          sendPrev_q;
  logic          key_q;
  logic          busy_q;
  logic          sendRise;
  morse_code_t   code;

  // The pattern is stored MSB-aligned so the current element is always bit 3.
  always_comb begin
    sendRise  = send_i & ~sendPrev_q;
    code      = codeOf(letter_i);
    state_d   = state_q;
    count_d   = count_q + 1'b1;
    pattern_d = pattern_q;
    remain_d  = remain_q;
    case (state_q)
      TX_IDLE: begin
        count_d = '0;
        if (sendRise && letter_i <= LAST_LETTER) begin
          state_d   = TX_MARK;
          pattern_d = code.pattern << (3'd4 - code.len);
          remain_d  = code.len;
        end
      end
      TX_MARK: begin
        if (count_q == (pattern_q[3] ? DASH_LAST : DOT_LAST)) begin
          count_d   = '0;
          pattern_d = {pattern_q[2:0], 1'b0};
          remain_d  = remain_q - 3'd1;
          state_d   = (remain_q == 3'd1) ? TX_LGAP : TX_SPACE;
        end
      end
      TX_SPACE: begin
        if (count_q == DOT_LAST) begin
          count_d = '0;
          state_d = TX_MARK;
        end
      end
      TX_LGAP: begin
        if (count_q == DASH_LAST) begin
          count_d = '0;
          state_d = TX_IDLE;
        end
      end
      default: begin
        count_d = '0;
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      count_q    <= '0;
      pattern_q  <= '0;
      remain_q   <= '0;
      sendPrev_q <= 1'b0;
      key_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pattern_q  <= pattern_d;
      remain_q   <= remain_d;
      sendPrev_q <= send_i;
      key_q      <= (state_q == TX_MARK);
      busy_q     <= (state_q != TX_IDLE);
    end
  end

  assign key_o  = key_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/morse_codec.sv
// TinyTapeout Morse codec top: synchronises the send and key inputs and maps
// the independent transmitter and receiver onto the user-project pins.
module morse_codec
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = UNIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       sendMeta_q, sendSync_q;
  logic       keyMeta_q, keySync_q;
  logic       txKey, txBusy;
  logic [4:0] rxLetter;
  logic       rxError, rxValid;
  logic       unusedInputs;

  // Both asynchronous pin inputs get a two-flop synchroniser before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sendMeta_q <= 1'b0;
      sendSync_q <= 1'b0;
      keyMeta_q  <= 1'b0;
      keySync_q  <= 1'b0;
    end else begin
      sendMeta_q <= ui_in[5];
      sendSync_q <= sendMeta_q;
      keyMeta_q  <= ui_in[6];
      keySync_q  <= keyMeta_q;
    end
  end

  morse_tx_fsm #(
    .UNIT(UNIT_CYCLES)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .send_i  (sendSync_q),
    .letter_i(ui_in[4:0]),
    .key_o   (txKey),
    .busy_o  (txBusy)
  );

  morse_rx_fsm #(
    .UNIT(UNIT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_i   (keySync_q),
    .letter_o(rxLetter),
    .error_o (rxError),
    .valid_o (rxValid)
  );

  assign uo_out       = {rxValid, rxLetter, txBusy, txKey};
  assign uio_out      = {7'b0, rxError};
  assign uio_oe       = 8'h01;
  assign unusedInputs = &{1'b0, ena, ui_in[7], uio_in};

endmodule

// File: tb/tb_morse_codec.sv
// Self-checking bench for morse_codec: random letters are checked against a
// dot/dash string model of Morse timing and decoding.
`timescale 1ns/1ps
module tb_morse_codec;

  localparam int UNIT = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] uiIn;
  logic [7:0] uoOut;
  logic [7:0] uioIn;
  logic [7:0] uioOut;
  logic [7:0] uioOe;

  logic [4:0] txIdx;
  logic       sendReq;
  logic       rxKey;
  logic       loopback;

  int checks   = 0;
  int failures = 0;

  string morseTbl[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

  bit expKey[$];
  bit keyTrace[$];
  bit busyTrace[$];
  int validSeen;
  int validLetter;
  int validErr;

  assign uiIn = {1'b0, (loopback ? uoOut[0] : rxKey), sendReq, txIdx};

  always #5 clk = ~clk;

  morse_codec #(
    .UNIT_CYCLES(UNIT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (uiIn),
    .uo_out (uoOut),
    .uio_in (uioIn),
    .uio_out(uioOut),
    .uio_oe (uioOe)
  );

  function automatic int modelDecode(input string s);
    int r;
    r = 31;
    for (int i = 0; i < 26; i++) begin
      if (morseTbl[i] == s) r = i;
    end
    return r;
  endfunction

  // Ideal key waveform for one letter: marks, unit spaces, then the 3-unit gap.
  function automatic void buildTxWave(input int idx);
    string s;
    int    onLen;
    s = morseTbl[idx];
    expKey.delete();
    for (int e = 0; e < s.len(); e++) begin
      onLen = (s[e] == "-") ? 3 * UNIT : UNIT;
      if (e > 0) repeat (UNIT) expKey.push_back(1'b0);
      repeat (onLen) expKey.push_back(1'b1);
    end
    repeat (3 * UNIT) expKey.push_back(1'b0);
  endfunction

  // Trace entry j is sampled j+1 negedges after the send edge; key first rises at j = 3.
  function automatic int keyMismatches();
    int bad;
    bit e;
    bad = 0;
    for (int j = 0; j < keyTrace.size(); j++) begin
      e = (j >= 3 && j - 3 < expKey.size()) ? expKey[j - 3] : 1'b0;
      if (keyTrace[j] != e) bad++;
    end
    return bad;
  endfunction

  function automatic int busyMismatches();
    int bad;
    bit e;
    bad = 0;
    for (int j = 0; j < busyTrace.size(); j++) begin
      e = (j >= 3 && j - 3 < expKey.size());
      if (busyTrace[j] != e) bad++;
    end
    return bad;
  endfunction

  function automatic int onesIn(input bit useBusy);
    int n;
    n = 0;
    for (int j = 0; j < keyTrace.size(); j++) begin
      if (useBusy ? busyTrace[j] : keyTrace[j]) n++;
    end
    return n;
  endfunction

  task automatic sampleValid();
    if (uoOut[7]) begin
      validSeen++;
      validLetter = int'(uoOut[6:2]);
      validErr    = int'(uioOut[0]);
    end
  endtask

  task automatic runTx(input int idx, input int cycles, input int retryAt, input int retryIdx);
    keyTrace.delete();
    busyTrace.delete();
    validSeen = 0;
    @(negedge clk);
    txIdx   = 5'(idx);
    sendReq = 1'b1;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      keyTrace.push_back(uoOut[0]);
      busyTrace.push_back(uoOut[1]);
      sampleValid();
      if (i == 1) sendReq = 1'b0;
      if (i == retryAt) begin
        txIdx   = 5'(retryIdx);
        sendReq = 1'b1;
      end
      if (i == retryAt + 1) sendReq = 1'b0;
    end
  endtask

  task automatic driveKey(input logic level, input int cycles);
    rxKey = level;
    repeat (cycles) begin
      @(negedge clk);
      sampleValid();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (uoOut !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_uo_out: got %h, required 00", uoOut);
    end
    checks++;
    if (uioOut !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_uio_out: got %h, required 00", uioOut);
    end
    checks++;
    if (uioOe !== 8'h01) begin
      failures++;
      $display("[TB] FAIL reset_uio_oe: got %h, required 01", uioOe);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (uoOut !== 8'h00) begin
      failures++;
      $display("[TB] FAIL idle_uo_out: got %h, required 00", uoOut);
    end
  endtask

  task automatic test_send_e();
    int bad;
    buildTxWave(4);
    runTx(4, expKey.size() + 40, 20, 19);
    bad = keyMismatches();
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL e_key_wave: %0d mismatching cycles, required 0", bad);
    end
    bad = busyMismatches();
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL e_busy_wave: %0d mismatching cycles, required 0", bad);
    end
    checks++;
    if (onesIn(1'b1) != 64) begin
      failures++;
      $display("[TB] FAIL e_busy_len: got %0d cycles, required 64", onesIn(1'b1));
    end
    checks++;
    if (onesIn(1'b0) != 16) begin
      failures++;
      $display("[TB] FAIL e_key_len: got %0d cycles, required 16", onesIn(1'b0));
    end
  endtask

  task automatic test_send_a();
    int bad;
    buildTxWave(0);
    runTx(0, expKey.size() + 20, -5, 0);
    bad = keyMismatches();
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL a_key_wave: %0d mismatching cycles, required 0", bad);
    end
    checks++;
    if (onesIn(1'b1) != 128) begin
      failures++;
      $display("[TB] FAIL a_busy_len: got %0d cycles, required 128", onesIn(1'b1));
    end
  endtask

  task automatic test_rx_direct();
    validSeen = 0;
    driveKey(1'b1, 20);
    driveKey(1'b0, 60);
    checks++;
    if (validSeen != 1 || validLetter != 4 || validErr != 0) begin
      failures++;
      $display("[TB] FAIL rx_e: pulses %0d letter %0d err %0d, required 1 4 0",
               validSeen, validLetter, validErr);
    end
    validSeen = 0;
    driveKey(1'b1, 50);
    driveKey(1'b0, 16);
    driveKey(1'b1, 16);
    driveKey(1'b0, 60);
    checks++;
    if (validSeen != 1 || validLetter != 13 || validErr != 0) begin
      failures++;
      $display("[TB] FAIL rx_n: pulses %0d letter %0d err %0d, required 1 13 0",
               validSeen, validLetter, validErr);
    end
  endtask

  task automatic test_rx_error();
    validSeen = 0;
    for (int e = 0; e < 6; e++) begin
      driveKey(1'b1, 16);
      driveKey(1'b0, (e == 5) ? 60 : 16);
    end
    checks++;
    if (validSeen != 1 || validLetter != 31 || validErr != 1) begin
      failures++;
      $display("[TB] FAIL rx_six_dots: pulses %0d letter %0d err %0d, required 1 31 1",
               validSeen, validLetter, validErr);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (uoOut[6:2] !== 5'd31 || uioOut[0] !== 1'b1 || uoOut[7] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rx_hold: letter %0d err %b valid %b, required 31 1 0",
               uoOut[6:2], uioOut[0], uoOut[7]);
    end
  endtask

  task automatic test_rx_random();
    string s;
    int    n;
    int    expLetter;
    int    expErr;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 5);
      s = "";
      for (int e = 0; e < n; e++) begin
        if ($urandom_range(0, 1) == 1) s = {s, "-"};
        else s = {s, "."};
      end
      expLetter = modelDecode(s);
      expErr    = (expLetter == 31) ? 1 : 0;
      validSeen = 0;
      for (int e = 0; e < n; e++) begin
        driveKey(1'b1, (s[e] == "-") ? $urandom_range(38, 60) : $urandom_range(8, 26));
        driveKey(1'b0, (e == n - 1) ? 60 : $urandom_range(8, 26));
      end
      checks++;
      if (validSeen != 1 || validLetter != expLetter || validErr != expErr) begin
        failures++;
        $display("[TB] FAIL rx_random %s: pulses %0d letter %0d err %0d, required 1 %0d %0d",
                 s, validSeen, validLetter, validErr, expLetter, expErr);
      end
    end
  endtask

  task automatic test_loopback();
    int letters[5];
    int bad;
    letters[0] = 16;
    letters[1] = 25;
    for (int k = 2; k < 5; k++) letters[k] = $urandom_range(0, 25);
    rxKey    = 1'b0;
    loopback = 1'b1;
    for (int k = 0; k < 5; k++) begin
      buildTxWave(letters[k]);
      runTx(letters[k], expKey.size() + 10, -5, 0);
      bad = keyMismatches();
      checks++;
      if (bad != 0) begin
        failures++;
        $display("[TB] FAIL loop_key_wave %0d: %0d mismatching cycles, required 0", letters[k], bad);
      end
      checks++;
      if (validSeen != 1 || validLetter != letters[k] || validErr != 0) begin
        failures++;
        $display("[TB] FAIL loop_decode: pulses %0d letter %0d err %0d, required 1 %0d 0",
                 validSeen, validLetter, validErr, letters[k]);
      end
    end
    loopback = 1'b0;
  endtask

  task automatic test_invalid_index();
    int badIdx[2];
    badIdx[0] = 30;
    badIdx[1] = 26;
    for (int k = 0; k < 2; k++) begin
      runTx(badIdx[k], 40, -5, 0);
      checks++;
      if (onesIn(1'b0) != 0 || onesIn(1'b1) != 0) begin
        failures++;
        $display("[TB] FAIL invalid_index %0d: key cycles %0d busy cycles %0d, required 0 0",
                 badIdx[k], onesIn(1'b0), onesIn(1'b1));
      end
    end
  endtask

  task automatic test_reset_mid_dash();
    int keyOnes;
    @(negedge clk);
    txIdx   = 5'd19;
    sendReq = 1'b1;
    @(negedge clk);
    sendReq = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (uoOut[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_dash_key: got %b, required 1", uoOut[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (uoOut[0] !== 1'b0 || uoOut[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_abort: key %b busy %b, required 0 0", uoOut[0], uoOut[1]);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    keyOnes = 0;
    repeat (60) begin
      @(negedge clk);
      if (uoOut[0] || uoOut[1]) keyOnes++;
    end
    checks++;
    if (keyOnes != 0) begin
      failures++;
      $display("[TB] FAIL after_abort: %0d active cycles, required 0", keyOnes);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    uioIn    = 8'h00;
    txIdx    = 5'd0;
    sendReq  = 1'b0;
    rxKey    = 1'b0;
    loopback = 1'b0;
    test_reset();
    test_send_e();
    test_send_a();
    test_rx_direct();
    test_rx_error();
    test_rx_random();
    test_loopback();
    test_invalid_index();
    test_reset_mid_dash();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
